// File: rtl/axis_bram_stream_master.sv
// AXI4-Stream master fed from a BRAM read engine: beats are buffered in a FIFO,
// and TLAST is either passed through from the user side or generated from PKT_LEN.
module axis_bram_stream_master #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int C_FIFO_DEPTH         = 16,
    parameter int C_M_START_COUNT      = 32,
    parameter int C_PKT_LEN_WIDTH      = 16
) (
    input  logic                              M_AXIS_ACLK,
    input  logic                              M_AXIS_ARESETN,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   DIN_DATA,
    input  logic                              DIN_VALID,
    input  logic                              DIN_TLAST,
    output logic                              DIN_ACCEP,
    input  logic                              CFG_AUTO_TLAST,
    input  logic [C_PKT_LEN_WIDTH-1:0]        PKT_LEN,
    output logic                              M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic                              M_AXIS_TLAST,
    input  logic                              M_AXIS_TREADY,
    output logic [$clog2(C_FIFO_DEPTH):0]     FILL_LEVEL,
    output logic                              BUSY,
    output logic                              PKT_DONE
);

    localparam int DW        = C_M_AXIS_TDATA_WIDTH;
    localparam int AW        = $clog2(C_FIFO_DEPTH);
    localparam int CW        = AW + 1;
    localparam int WAIT_W    = (C_M_START_COUNT > 1) ? $clog2(C_M_START_COUNT) : 1;
    localparam int WAIT_LAST = (C_M_START_COUNT > 0) ? C_M_START_COUNT - 1 : 0;
    localparam logic [C_PKT_LEN_WIDTH-1:0] LEN_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SEND,
        S_DRAIN
    } state_t;

    state_t                     state;
    logic [WAIT_W-1:0]          wait_cnt;
    logic [C_PKT_LEN_WIDTH-1:0] beat_cnt;
    logic [C_PKT_LEN_WIDTH-1:0] len_m1;
    logic                       auto_mode;

    logic [DW:0]                mem [C_FIFO_DEPTH];
    logic [AW-1:0]              wr_ptr;
    logic [AW-1:0]              rd_ptr;
    logic [CW-1:0]              mem_count;
    logic                       out_valid;
    logic [DW-1:0]              out_data;
    logic                       out_last;

    logic push;
    logic pop;
    logic push_last;
    logic load_out;
    logic from_mem;
    logic bypass;
    logic mem_wr;

    // The output register counts as one FIFO entry, so total occupancy is mem + output stage.
    assign FILL_LEVEL = mem_count + CW'(out_valid);
    assign DIN_ACCEP  = (state == S_SEND) && (FILL_LEVEL < CW'(C_FIFO_DEPTH));

    assign push      = DIN_VALID && DIN_ACCEP;
    assign pop       = out_valid && M_AXIS_TREADY;
    assign push_last = auto_mode ? (beat_cnt == len_m1) : DIN_TLAST;
    assign load_out  = !out_valid || pop;
    assign from_mem  = load_out && (mem_count != '0);
    assign bypass    = load_out && (mem_count == '0) && push;
    assign mem_wr    = push && !bypass;

    assign M_AXIS_TVALID = out_valid;
    assign M_AXIS_TDATA  = out_data;
    assign M_AXIS_TLAST  = out_last;
    assign M_AXIS_TSTRB  = '1;
    assign BUSY          = (state != S_IDLE);
    assign PKT_DONE      = pop && out_last;

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            beat_cnt  <= '0;
            len_m1    <= '0;
            auto_mode <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    auto_mode <= CFG_AUTO_TLAST;
                    len_m1    <= (PKT_LEN == '0) ? '0 : PKT_LEN - LEN_ONE;
                    beat_cnt  <= '0;
                    wait_cnt  <= '0;
                    state     <= (C_M_START_COUNT == 0) ? S_SEND : S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_W'(WAIT_LAST)) begin
                        state <= S_SEND;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_SEND: begin
                    if (push) begin
                        beat_cnt <= beat_cnt + LEN_ONE;
                        if (push_last) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && out_last) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (mem_wr) begin
            mem[wr_ptr] <= {push_last, DIN_DATA};
        end
    end

    // An empty FIFO forwards the incoming beat straight into the output stage for one-cycle latency.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (mem_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (from_mem) begin
                out_valid              <= 1'b1;
                {out_last, out_data}   <= mem[rd_ptr];
                rd_ptr                 <= rd_ptr + AW'(1);
            end else if (bypass) begin
                out_valid <= 1'b1;
                out_data  <= DIN_DATA;
                out_last  <= push_last;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
            case ({mem_wr, from_mem})
                2'b10:   mem_count <= mem_count + CW'(1);
                2'b01:   mem_count <= mem_count - CW'(1);
                default: mem_count <= mem_count;
            endcase
        end
    end

endmodule

// File: doc/axis_bram_stream_master.md
Name: axis_bram_stream_master

Overview:
Parametrised AXI4-Stream master that takes user/BRAM-side beats on a DIN_* valid/accept handshake and drives a standard AXIS master port.
- Buffers beats in an internal FIFO, so AXIS back-pressure never drops or corrupts data.
- TLAST is either passed through from the user side or generated from a programmable packet length.
- Sits between the BRAM read engine and the downstream AXIS interconnect/DMA, one packet at a time.

Parameters:
C_M_AXIS_TDATA_WIDTH, 32, data width in bits; multiple of 8.
C_FIFO_DEPTH, 16, FIFO entries; power of 2, >= 2.
C_M_START_COUNT, 32, idle cycles inserted before each packet; 0 = no delay.
C_PKT_LEN_WIDTH, 16, width of PKT_LEN and of the beat counter.

Ports:
M_AXIS_ACLK  in  1  clock, all logic on rising edge
M_AXIS_ARESETN  in  1  reset, asynchronous, active-low
DIN_DATA  in  C_M_AXIS_TDATA_WIDTH  user beat data
DIN_VALID  in  1  user beat valid
DIN_TLAST  in  1  user last-beat flag (pass-through mode only)
DIN_ACCEP  out  1  block accepts a beat this cycle when DIN_VALID=1
CFG_AUTO_TLAST  in  1  1 = TLAST from PKT_LEN, 0 = TLAST from DIN_TLAST; latched at packet start
PKT_LEN  in  C_PKT_LEN_WIDTH  beats per packet in auto mode; latched at packet start; 0 treated as 1
M_AXIS_TVALID  out  1  AXIS valid
M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  AXIS data
M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8  constant all-ones
M_AXIS_TLAST  out  1  AXIS last
M_AXIS_TREADY  in  1  AXIS ready
FILL_LEVEL  out  clog2(C_FIFO_DEPTH)+1  entries currently held
BUSY  out  1  state != IDLE
PKT_DONE  out  1  one-cycle pulse on the output handshake of the TLAST beat

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE; FIFO empty; counters 0.
  - TVALID=0, TLAST=0, TDATA=0, DIN_ACCEP=0, FILL_LEVEL=0, BUSY=0, PKT_DONE=0.
  - Reset mid-packet discards all buffered beats; no partial TLAST is emitted.
- FSM states and transitions:
  - IDLE -> WAIT next cycle (WAIT is skipped straight to SEND if C_M_START_COUNT=0). The IDLE->WAIT/SEND transition latches CFG_AUTO_TLAST and PKT_LEN, and clears the beat counter.
  - WAIT: counts C_M_START_COUNT cycles, then -> SEND.
  - SEND: runs until the last beat is pushed, then -> DRAIN.
  - DRAIN: -> IDLE in the cycle after the TLAST beat handshakes on AXIS.
- Input handshake:
  - DIN_ACCEP = (state==SEND) && (FILL_LEVEL < C_FIFO_DEPTH).
  - DIN_ACCEP is combinational from registered state only; there is no path from M_AXIS_TREADY.
  - A push occurs when DIN_VALID && DIN_ACCEP.
- Last beat:
  - Auto mode: the push where beat counter == max(PKT_LEN,1)-1. DIN_TLAST is ignored.
  - Pass-through mode: the push with DIN_TLAST=1.
  - The beat counter wraps at 2^C_PKT_LEN_WIDTH in pass-through mode.
- FIFO: stores {data, last} per entry.
  - Latency: push in cycle N to an empty FIFO gives TVALID=1 with that data in cycle N+1.
  - Throughput is 1 beat/cycle sustained when TREADY=1.
- AXIS rules:
  - Once TVALID=1, TVALID, TDATA and TLAST are held stable until TREADY=1.
  - TVALID never drops without a handshake.
  - When TVALID=0, TDATA and TLAST hold their last values (0 after reset).
- Simultaneous push and pop: FILL_LEVEL is unchanged. At full, no push is accepted even if a pop occurs that cycle.
- FILL_LEVEL counts all held entries, including the one presented on TDATA. Range 0..C_FIFO_DEPTH.
- Between packets, beats are never accepted outside SEND, so packets never interleave.

Test Plan:
- Pass-through, depth 16, start 4, TREADY=1, 8 beats 0x1..0x8 with DIN_TLAST on 0x8 -> DIN_ACCEP rises 5 cycles after IDLE; TDATA 0x1..0x8 each 1 cycle after its push; TLAST only with 0x8; PKT_DONE pulses once; BUSY low 1 cycle later.
- Auto mode, PKT_LEN=5, DIN_VALID held high with DIN_TLAST=0 -> exactly 5 beats accepted; TLAST on the 5th; DIN_ACCEP=0 through DRAIN; next packet starts after another start delay.
- Back-pressure, TREADY=0 while 20 beats are offered, depth 16 -> FILL_LEVEL saturates at 16; DIN_ACCEP=0 at full; TDATA/TVALID stable; release TREADY -> all 20 beats out in order, none lost.
- TREADY toggling every cycle with continuous push -> no duplicate or dropped beats; FILL_LEVEL never exceeds 16; simultaneous push+pop leaves the level unchanged.
- PKT_LEN=0, auto mode -> single-beat packet with TLAST=1.
- ARESETN asserted mid-packet with 6 beats buffered -> all outputs 0 immediately (async); after release, FIFO empty and the FSM restarts from IDLE with the full start delay.
